// File: rtl/trap_ctrl_pkg.sv
// Shared encodings for the machine-mode trap sequencer: FSM states, PC sources and cause codes.
// Pure definitions; no timing or flow control.
package trap_ctrl_pkg;

  localparam logic [1:0] ST_RESET       = 2'b00;
  localparam logic [1:0] ST_OPERATING   = 2'b01;
  localparam logic [1:0] ST_TRAP_TAKEN  = 2'b10;
  localparam logic [1:0] ST_TRAP_RETURN = 2'b11;

  localparam logic [1:0] PC_BOOT  = 2'b00;
  localparam logic [1:0] PC_EPC   = 2'b01;
  localparam logic [1:0] PC_TRAP  = 2'b10;
  localparam logic [1:0] PC_SEQ   = 2'b11;

  localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  typedef struct packed {
    logic       valid;
    logic       i_or_e;
    logic [3:0] cause;
  } trap_req_t;

endpackage

// File: rtl/trap_control_if.sv
// Event/enable inputs and CSR strobe outputs of the trap sequencer.
// slave = trap_control, master = the pipeline/CSR side driving events.
interface trap_control_if;
  logic       stall_in;
  logic       instr_misaligned_in;
  logic       illegal_instr_in;
  logic       ecall_in;
  logic       ebreak_in;
  logic       load_misaligned_in;
  logic       store_misaligned_in;
  logic       mret_in;
  logic       mie_in;
  logic       meie_in;
  logic       mtie_in;
  logic       msie_in;
  logic       meip_in;
  logic       mtip_in;
  logic       msip_in;

  logic       i_or_e_out;
  logic [3:0] cause_out;
  logic       set_cause_out;
  logic       set_epc_out;
  logic       mie_clear_out;
  logic       mie_set_out;
  logic       instret_inc_out;
  logic [1:0] pc_src_out;
  logic       flush_out;
  logic       trap_taken_out;

  modport master (
    output stall_in, instr_misaligned_in, illegal_instr_in, ecall_in, ebreak_in,
           load_misaligned_in, store_misaligned_in, mret_in,
           mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
    input  i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out,
           mie_set_out, instret_inc_out, pc_src_out, flush_out, trap_taken_out
  );

  modport slave (
    input  stall_in, instr_misaligned_in, illegal_instr_in, ecall_in, ebreak_in,
           load_misaligned_in, store_misaligned_in, mret_in,
           mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
    output i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out,
           mie_set_out, instret_inc_out, pc_src_out, flush_out, trap_taken_out
  );
endinterface

// File: rtl/trap_priority_enc.sv
// Combinational trap priority encoder: enabled interrupts (MEI > MSI > MTI) beat exceptions.
// Zero latency, no state; cause is forced to 0 when nothing is selected.
module trap_priority_enc
  import trap_ctrl_pkg::*;
(
  input  logic      instr_misaligned,
  input  logic      illegal_instr,
  input  logic      ecall,
  input  logic      ebreak,
  input  logic      load_misaligned,
  input  logic      store_misaligned,
  input  logic      mie,
  input  logic      meie,
  input  logic      mtie,
  input  logic      msie,
  input  logic      meip,
  input  logic      mtip,
  input  logic      msip,
  output trap_req_t req
);

  always_comb begin
    req = '0;
    if (mie && meie && meip) begin
      req = '{valid: 1'b1, i_or_e: 1'b1, cause: IRQ_MEI};
    end else if (mie && msie && msip) begin
      req = '{valid: 1'b1, i_or_e: 1'b1, cause: IRQ_MSI};
    end else if (mie && mtie && mtip) begin
      req = '{valid: 1'b1, i_or_e: 1'b1, cause: IRQ_MTI};
    end else if (instr_misaligned) begin
      req = '{valid: 1'b1, i_or_e: 1'b0, cause: CAUSE_INSTR_MISALIGNED};
    end else if (illegal_instr) begin
      req = '{valid: 1'b1, i_or_e: 1'b0, cause: CAUSE_ILLEGAL_INSTR};
    end else if (ebreak) begin
      req = '{valid: 1'b1, i_or_e: 1'b0, cause: CAUSE_BREAKPOINT};
    end else if (ecall) begin
      req = '{valid: 1'b1, i_or_e: 1'b0, cause: CAUSE_ECALL_M};
    end else if (load_misaligned) begin
      req = '{valid: 1'b1, i_or_e: 1'b0, cause: CAUSE_LOAD_MISALIGNED};
    end else if (store_misaligned) begin
      req = '{valid: 1'b1, i_or_e: 1'b0, cause: CAUSE_STORE_MISALIGNED};
    end
  end

endmodule

// File: rtl/trap_control.sv
// Machine-mode trap sequencer: FSM, boot counter and combinational CSR strobe / PC-source decode.
// Strobes are same-cycle; stall_in freezes the FSM in OPERATING and suppresses every strobe.
module trap_control
  import trap_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  trap_control_if.slave tc
);

  logic [1:0] state_q, state_d;
  logic [3:0] boot_cnt_q, boot_cnt_d;
  trap_req_t  req;

  logic       i_or_e;
  logic [3:0] cause;
  logic       set_cause;
  logic       set_epc;
  logic       mie_clear;
  logic       mie_set;
  logic       instret_inc;
  logic [1:0] pc_src;
  logic       flush;
  logic       trap_taken;

  trap_priority_enc u_prio (
    .instr_misaligned (tc.instr_misaligned_in),
    .illegal_instr    (tc.illegal_instr_in),
    .ecall            (tc.ecall_in),
    .ebreak           (tc.ebreak_in),
    .load_misaligned  (tc.load_misaligned_in),
    .store_misaligned (tc.store_misaligned_in),
    .mie              (tc.mie_in),
    .meie             (tc.meie_in),
    .mtie             (tc.mtie_in),
    .msie             (tc.msie_in),
    .meip             (tc.meip_in),
    .mtip             (tc.mtip_in),
    .msip             (tc.msip_in),
    .req              (req)
  );

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    i_or_e      = 1'b0;
    cause       = 4'd0;
    set_cause   = 1'b0;
    set_epc     = 1'b0;
    mie_clear   = 1'b0;
    mie_set     = 1'b0;
    instret_inc = 1'b0;
    pc_src      = PC_SEQ;
    flush       = 1'b0;
    trap_taken  = 1'b0;

    case (state_q)
      ST_RESET: begin
        pc_src = PC_BOOT;
        flush  = 1'b1;
        if (boot_cnt_q == 4'(BOOT_CYCLES - 1)) begin
          state_d    = ST_OPERATING;
          boot_cnt_d = 4'd0;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end

      ST_OPERATING: begin
        if (!tc.stall_in) begin
          if (req.valid) begin
            // The trapping instruction is killed, so it never counts as retired.
            i_or_e     = req.i_or_e;
            cause      = req.cause;
            set_cause  = 1'b1;
            set_epc    = 1'b1;
            mie_clear  = 1'b1;
            trap_taken = 1'b1;
            flush      = 1'b1;
            pc_src     = PC_TRAP;
            state_d    = ST_TRAP_TAKEN;
          end else if (tc.mret_in) begin
            mie_set     = 1'b1;
            instret_inc = 1'b1;
            flush       = 1'b1;
            pc_src      = PC_EPC;
            state_d     = ST_TRAP_RETURN;
          end else begin
            instret_inc = 1'b1;
          end
        end
      end

      ST_TRAP_TAKEN: begin
        flush   = 1'b1;
        pc_src  = PC_TRAP;
        state_d = ST_OPERATING;
      end

      ST_TRAP_RETURN: begin
        flush   = 1'b1;
        pc_src  = PC_EPC;
        state_d = ST_OPERATING;
      end

      default: begin
        pc_src  = PC_BOOT;
        flush   = 1'b1;
        state_d = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_RESET;
      boot_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  assign tc.i_or_e_out      = i_or_e;
  assign tc.cause_out       = cause;
  assign tc.set_cause_out   = set_cause;
  assign tc.set_epc_out     = set_epc;
  assign tc.mie_clear_out   = mie_clear;
  assign tc.mie_set_out     = mie_set;
  assign tc.instret_inc_out = instret_inc;
  assign tc.pc_src_out      = pc_src;
  assign tc.flush_out       = flush;
  assign tc.trap_taken_out  = trap_taken;

endmodule

// File: tb/tb_trap_control.sv
// Bench for trap_control: reset/boot, a vector table, multi-cycle corner sequences
// and randomized traffic against a rule-list reference model.
module tb_trap_control;

  typedef struct packed {
    logic stall;
    logic imis;
    logic ill;
    logic ecall;
    logic ebreak;
    logic lmis;
    logic smis;
    logic mret;
    logic mie;
    logic meie;
    logic mtie;
    logic msie;
    logic meip;
    logic mtip;
    logic msip;
  } in_t;

  typedef struct packed {
    logic       i_or_e;
    logic [3:0] cause;
    logic       set_cause;
    logic       set_epc;
    logic       mie_clear;
    logic       mie_set;
    logic       instret_inc;
    logic       trap_taken;
    logic       flush;
    logic [1:0] pc_src;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  localparam int PH_BOOT = 0, PH_OPER = 1, PH_AFTER_TRAP = 2, PH_AFTER_MRET = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  trap_control_if bus ();

  trap_control #(.BOOT_CYCLES(1)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .tc     (bus)
  );

  task automatic drive(input in_t i);
    bus.stall_in            = i.stall;
    bus.instr_misaligned_in = i.imis;
    bus.illegal_instr_in    = i.ill;
    bus.ecall_in            = i.ecall;
    bus.ebreak_in           = i.ebreak;
    bus.load_misaligned_in  = i.lmis;
    bus.store_misaligned_in = i.smis;
    bus.mret_in             = i.mret;
    bus.mie_in              = i.mie;
    bus.meie_in             = i.meie;
    bus.mtie_in             = i.mtie;
    bus.msie_in             = i.msie;
    bus.meip_in             = i.meip;
    bus.mtip_in             = i.mtip;
    bus.msip_in             = i.msip;
  endtask

  task automatic check(input string nm, input out_t exp);
    out_t act;
    act = '{i_or_e: bus.i_or_e_out, cause: bus.cause_out, set_cause: bus.set_cause_out,
            set_epc: bus.set_epc_out, mie_clear: bus.mie_clear_out, mie_set: bus.mie_set_out,
            instret_inc: bus.instret_inc_out, trap_taken: bus.trap_taken_out,
            flush: bus.flush_out, pc_src: bus.pc_src_out};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected-value builders, in the vocabulary of the CSR interface
  function automatic out_t o_boot();
    return '{flush: 1'b1, pc_src: 2'b00, default: '0};
  endfunction
  function automatic out_t o_retire();
    return '{instret_inc: 1'b1, pc_src: 2'b11, default: '0};
  endfunction
  function automatic out_t o_stalled();
    return '{pc_src: 2'b11, default: '0};
  endfunction
  function automatic out_t o_trap(input logic irq, input logic [3:0] c);
    return '{i_or_e: irq, cause: c, set_cause: 1'b1, set_epc: 1'b1, mie_clear: 1'b1,
             trap_taken: 1'b1, flush: 1'b1, pc_src: 2'b10, default: '0};
  endfunction
  function automatic out_t o_mret();
    return '{mie_set: 1'b1, instret_inc: 1'b1, flush: 1'b1, pc_src: 2'b01, default: '0};
  endfunction
  function automatic out_t o_follow(input logic [1:0] pc);
    return '{flush: 1'b1, pc_src: pc, default: '0};
  endfunction

  // Reference model: walk ordered rule lists, first match wins
  function automatic out_t model(input int ph, input in_t i);
    logic       irq_hit[3];
    int         irq_code[3];
    logic       exc_hit[6];
    int         exc_code[6];
    case (ph)
      PH_BOOT:       return o_boot();
      PH_AFTER_TRAP: return o_follow(2'b10);
      PH_AFTER_MRET: return o_follow(2'b01);
      default: ;
    endcase
    if (i.stall) return o_stalled();
    irq_hit  = '{i.meie & i.meip, i.msie & i.msip, i.mtie & i.mtip};
    irq_code = '{11, 3, 7};
    exc_hit  = '{i.imis, i.ill, i.ebreak, i.ecall, i.lmis, i.smis};
    exc_code = '{0, 2, 3, 11, 4, 6};
    if (i.mie)
      for (int k = 0; k < 3; k++)
        if (irq_hit[k]) return o_trap(1'b1, 4'(irq_code[k]));
    for (int k = 0; k < 6; k++)
      if (exc_hit[k]) return o_trap(1'b0, 4'(exc_code[k]));
    if (i.mret) return o_mret();
    return o_retire();
  endfunction

  function automatic int next_phase(input int ph, input in_t i);
    out_t o;
    if (ph != PH_OPER) return PH_OPER;
    o = model(ph, i);
    if (o.trap_taken) return PH_AFTER_TRAP;
    if (o.mie_set) return PH_AFTER_MRET;
    return PH_OPER;
  endfunction

  task automatic add(input string n, input in_t i, input out_t o);
    vec_t v;
    v.name = n;
    v.in   = i;
    v.exp  = o;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t idle;
    in_t r;
    int  ph;
    out_t e;
    idle = '0;
    drive(idle);

    add("normal_retire",   '{default: 1'b0},                                          o_retire());
    add("ill_plus_ecall",  '{ill: 1'b1, ecall: 1'b1, default: 1'b0},                  o_trap(1'b0, 4'd2));
    add("all_irq_pending", '{mie: 1'b1, meie: 1'b1, mtie: 1'b1, msie: 1'b1,
                             meip: 1'b1, mtip: 1'b1, msip: 1'b1, default: 1'b0},      o_trap(1'b1, 4'd11));
    add("msi_over_mti",    '{mie: 1'b1, meie: 1'b1, mtie: 1'b1, msie: 1'b1,
                             mtip: 1'b1, msip: 1'b1, default: 1'b0},                  o_trap(1'b1, 4'd3));
    add("mti_masked_mie",  '{mtie: 1'b1, mtip: 1'b1, default: 1'b0},                  o_retire());
    add("mti_unmasked",    '{mie: 1'b1, mtie: 1'b1, mtip: 1'b1, default: 1'b0},       o_trap(1'b1, 4'd7));
    add("mret_alone",      '{mret: 1'b1, default: 1'b0},                              o_mret());
    add("mret_vs_msi",     '{mret: 1'b1, mie: 1'b1, msie: 1'b1, msip: 1'b1,
                             default: 1'b0},                                          o_trap(1'b1, 4'd3));
    add("stall_lmis",      '{stall: 1'b1, lmis: 1'b1, default: 1'b0},                 o_stalled());
    add("lmis",            '{lmis: 1'b1, default: 1'b0},                              o_trap(1'b0, 4'd4));
    add("ebreak_vs_ecall", '{ebreak: 1'b1, ecall: 1'b1, default: 1'b0},               o_trap(1'b0, 4'd3));
    add("smis",            '{smis: 1'b1, default: 1'b0},                              o_trap(1'b0, 4'd6));
    add("mei_vs_exc",      '{imis: 1'b1, ill: 1'b1, mie: 1'b1, meie: 1'b1, meip: 1'b1,
                             default: 1'b0},                                          o_trap(1'b1, 4'd11));
    add("pend_no_enable",  '{mie: 1'b1, mtip: 1'b1, msip: 1'b1, meip: 1'b1,
                             default: 1'b0},                                          o_retire());
    add("imis_vs_smis",    '{imis: 1'b1, smis: 1'b1, mret: 1'b1, default: 1'b0},      o_trap(1'b0, 4'd0));

    // Reset and boot
    #2;
    check("reset_state", o_boot());
    step();
    check("reset_held", o_boot());
    rst_n = 1'b1;
    @(negedge clk);
    check("boot_cycle", o_boot());
    step();
    @(negedge clk);
    check("first_operating", o_retire());
    step();
    @(negedge clk);
    check("second_operating", o_retire());
    step();

    // Vector table; trap/MRET entries are followed by their single flush cycle
    foreach (vecs[n]) begin
      drive(vecs[n].in);
      @(negedge clk);
      check(vecs[n].name, vecs[n].exp);
      step();
      if (vecs[n].exp.trap_taken || vecs[n].exp.mie_set) begin
        drive(idle);
        @(negedge clk);
        check({vecs[n].name, "_follow"}, o_follow(vecs[n].exp.trap_taken ? 2'b10 : 2'b01));
        step();
      end
    end

    // Stalled load-misaligned held three cycles, then released
    drive('{stall: 1'b1, lmis: 1'b1, default: 1'b0});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_hold_%0d", k), o_stalled());
      step();
    end
    drive('{lmis: 1'b1, default: 1'b0});
    @(negedge clk);
    check("stall_release_trap", o_trap(1'b0, 4'd4));
    step();
    // Trap pending during TRAP_TAKEN must not be taken that cycle
    drive('{ill: 1'b1, stall: 1'b1, default: 1'b0});
    @(negedge clk);
    check("tt_ignores_stall_trap", o_follow(2'b10));
    step();
    drive('{ill: 1'b1, default: 1'b0});
    @(negedge clk);
    check("trap_after_tt", o_trap(1'b0, 4'd2));
    step();

    // Asynchronous reset in the middle of TRAP_TAKEN
    drive(idle);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_in_tt", o_boot());
    step();
    check("reset_still_held", o_boot());
    rst_n = 1'b1;
    @(negedge clk);
    check("reboot_cycle", o_boot());
    step();
    @(negedge clk);
    check("reboot_operating", o_retire());
    step();

    // Randomized traffic against the reference model
    ph = PH_OPER;
    for (int c = 0; c < 400; c++) begin
      r = '0;
      r.stall  = ($urandom_range(0, 3) == 0);
      r.imis   = ($urandom_range(0, 9) == 0);
      r.ill    = ($urandom_range(0, 9) == 0);
      r.ecall  = ($urandom_range(0, 9) == 0);
      r.ebreak = ($urandom_range(0, 9) == 0);
      r.lmis   = ($urandom_range(0, 9) == 0);
      r.smis   = ($urandom_range(0, 9) == 0);
      r.mret   = ($urandom_range(0, 5) == 0);
      r.mie    = 1'($urandom_range(0, 1));
      r.meie   = 1'($urandom_range(0, 1));
      r.mtie   = 1'($urandom_range(0, 1));
      r.msie   = 1'($urandom_range(0, 1));
      r.meip   = ($urandom_range(0, 5) == 0);
      r.mtip   = ($urandom_range(0, 5) == 0);
      r.msip   = ($urandom_range(0, 5) == 0);
      drive(r);
      e = model(ph, r);
      @(negedge clk);
      check($sformatf("random_%0d", c), e);
      ph = next_phase(ph, r);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
